// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply engine.
//   state_t     : dot-product controller FSM states
//   calc_w_len  : width needed to hold an element count 0..max_len
//   calc_w_acc  : accumulator width that cannot overflow at max_len
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int calc_w_len(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Each product fits in w_a+w_b bits; summing up to 2**w_len of them
    // needs w_len extra bits.
    function automatic int calc_w_acc(input int w_a, input int w_b, input int w_len);
        return w_a + w_b + w_len;
    endfunction

endpackage

// File: rtl/noOverflowMult.sv
// Registered unsigned multiplier, one cycle of latency, full-width product.
// Ports:
//   Clock   in   sole clock
//   a       in   W_a  unsigned operand
//   b       in   W_b  unsigned operand
//   product out  W_a+W_b  a*b of the previous cycle
module noOverflowMult #(
    parameter int W_a = 32,
    parameter int W_b = 32
) (
    input  logic                 Clock,
    input  logic [W_a-1:0]       a,
    input  logic [W_b-1:0]       b,
    output logic [W_a+W_b-1:0]   product
);

    // Product register; operands widened first so no bits are lost.
    always_ff @(posedge Clock) begin
        product <= {{W_b{1'b0}}, a} * {{W_a{1'b0}}, b};
    end

endmodule

// File: rtl/dot_product_ctrl.sv
// Dot-product sequencer: accepts a job (start + length), pulls length
// operand pairs over a valid/ready stream, feeds them to a registered
// multiplier and accumulates the products without overflow. The sum is
// offered on a valid/ready result port.
// Ports:
//   Clock, Reset          clock and synchronous active-high reset
//   start, length         job request (sampled in IDLE only)
//   busy, err             not-idle flag; one-cycle reject pulse
//   in_valid/in_ready     operand pair handshake, in_a/in_b operands
//   result/result_valid/result_ready  dot product handshake
module dot_product_ctrl
    import mm_pkg::*;
#(
    parameter int W_a     = 32,
    parameter int W_b     = 32,
    parameter int MAX_LEN = 16,
    parameter int W_len   = calc_w_len(MAX_LEN),
    parameter int W_acc   = calc_w_acc(W_a, W_b, W_len)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              start,
    input  logic [W_len-1:0]  length,
    output logic              busy,
    output logic              err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_a-1:0]    in_a,
    input  logic [W_b-1:0]    in_b,
    output logic [W_acc-1:0]  result,
    output logic              result_valid,
    input  logic              result_ready
);

    localparam logic [W_len-1:0] MAX_LEN_V = W_len'(MAX_LEN);
    localparam logic [W_len-1:0] ONE_V     = W_len'(1'b1);
    localparam logic [W_len-1:0] ZERO_V    = W_len'(1'b0);

    state_t                 state_r;
    state_t                 state_nxt;
    logic [W_len-1:0]       count_r;
    logic [W_len-1:0]       len_r;
    logic [W_acc-1:0]       acc_r;
    logic [W_acc-1:0]       acc_sum_s;
    logic [W_acc-1:0]       result_r;
    logic                   err_r;
    logic                   pvalid_r;
    logic                   in_ready_s;
    logic                   accept_s;
    logic                   last_s;
    logic                   job_take_s;
    logic [W_a+W_b-1:0]     product_s;

    noOverflowMult #(
        .W_a (W_a),
        .W_b (W_b)
    ) u_mult (
        .Clock   (Clock),
        .a       (in_a),
        .b       (in_b),
        .product (product_s)
    );

    // Handshake qualifiers; in_ready drops as soon as the job has all its pairs.
    always_comb begin
        in_ready_s = (state_r == FEED) && (count_r != len_r);
        accept_s   = in_valid && in_ready_s;
        last_s     = accept_s && ((count_r + ONE_V) == len_r);
        job_take_s = (state_r == IDLE) && start;
        // The product in flight this cycle belongs to the pair accepted last cycle.
        if (pvalid_r) begin
            acc_sum_s = acc_r + W_acc'(product_s);
        end else begin
            acc_sum_s = acc_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (start && (length == ZERO_V)) begin
                    state_nxt = DONE;
                end else if (start && (length <= MAX_LEN_V)) begin
                    state_nxt = FEED;
                end else begin
                    state_nxt = IDLE;
                end
            end
            FEED: begin
                if (last_s) begin
                    state_nxt = DRAIN;
                end else begin
                    state_nxt = FEED;
                end
            end
            DRAIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (result_ready) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Counter, accumulator, product-valid flag, result and err registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_r  <= ZERO_V;
            len_r    <= ZERO_V;
            acc_r    <= '0;
            result_r <= '0;
            err_r    <= 1'b0;
            pvalid_r <= 1'b0;
        end else begin
            err_r    <= job_take_s && (length > MAX_LEN_V);
            pvalid_r <= accept_s;
            if (job_take_s) begin
                count_r <= ZERO_V;
                len_r   <= length;
                acc_r   <= '0;
            end else begin
                if (accept_s) begin
                    count_r <= count_r + ONE_V;
                end else begin
                    count_r <= count_r;
                end
                acc_r <= acc_sum_s;
            end
            // DRAIN's final product must be included, hence acc_sum_s not acc_r.
            if (job_take_s && (length == ZERO_V)) begin
                result_r <= '0;
            end else if (state_r == DRAIN) begin
                result_r <= acc_sum_s;
            end else begin
                result_r <= result_r;
            end
        end
    end

    assign busy         = (state_r != IDLE);
    assign result_valid = (state_r == DONE);
    assign in_ready     = in_ready_s;
    assign err          = err_r;
    assign result       = result_r;

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Self-checking bench for dot_product_ctrl (W_a=W_b=8, MAX_LEN=16).
// Expected dot products are pushed to a scoreboard queue when a job is
// started and popped when the DUT hands the result over.
module tb_dot_product_ctrl;

    localparam int W_A     = 8;
    localparam int W_B     = 8;
    localparam int MAX_LEN = 16;
    localparam int W_LEN   = 5;
    localparam int W_ACC   = 21;

    logic              Clock = 1'b0;
    logic              Reset;
    logic              start;
    logic [W_LEN-1:0]  length;
    logic              busy;
    logic              err;
    logic              in_valid;
    logic              in_ready;
    logic [W_A-1:0]    in_a;
    logic [W_B-1:0]    in_b;
    logic [W_ACC-1:0]  result;
    logic              result_valid;
    logic              result_ready;

    int n_cmp = 0;
    int n_bad = 0;
    longint exp_q[$];
    int va[$];
    int vb[$];
    bit vpat[$];

    dot_product_ctrl #(
        .W_a     (W_A),
        .W_b     (W_B),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .start        (start),
        .length       (length),
        .busy         (busy),
        .err          (err),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one job from va/vb. Inputs are driven and outputs observed at
    // negedges; cyc counts cycles after the one in which start was sampled.
    task automatic run_job(input string tag, input int len, input int ngaps, input int hold);
        int     idx  = 0;
        int     cnt  = 0;
        int     cyc  = 0;
        bit     done = 1'b0;
        longint sum  = 0;
        for (int i = 0; i < len; i++) begin
            sum += longint'(va[i]) * longint'(vb[i]);
        end
        @(negedge Clock);
        start  = 1'b1;
        length = W_LEN'(len);
        exp_q.push_back(sum);
        @(negedge Clock);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 200) begin
            if (result_valid) begin
                in_valid = 1'b0;
                check_val({tag, " latency"}, cyc, (len == 0) ? 1 : len + 2 + ngaps);
                check_val({tag, " consumed"}, cnt, len);
                check_val({tag, " in_ready_done"}, in_ready, 0);
                for (int h = 0; h < hold; h++) begin
                    result_ready = 1'b0;
                    if (h == 0) begin
                        start  = 1'b1;
                        length = W_LEN'(1);
                    end
                    @(negedge Clock);
                    start = 1'b0;
                    check_val({tag, " hold_valid"}, result_valid, 1);
                    check_val({tag, " hold_result"}, result, sum);
                    check_val({tag, " hold_busy"}, busy, 1);
                    check_val({tag, " hold_err"}, err, 0);
                end
                result_ready = 1'b1;
                check_val({tag, " result"}, result, exp_q.pop_front());
                @(negedge Clock);
                result_ready = 1'b0;
                check_val({tag, " valid_drop"}, result_valid, 0);
                check_val({tag, " busy_drop"}, busy, 0);
                done = 1'b1;
            end else begin
                in_valid = (vpat.size() > 0) ? vpat.pop_front() : 1'b1;
                in_a     = (idx < len) ? W_A'(va[idx]) : 8'hFF;
                in_b     = (idx < len) ? W_B'(vb[idx]) : 8'hFF;
                if (in_valid && in_ready) begin
                    cnt++;
                    idx++;
                end
                @(negedge Clock);
                cyc++;
            end
        end
        if (!done) begin
            check_val({tag, " timeout"}, 1, 0);
            void'(exp_q.pop_front());
        end
        in_valid = 1'b0;
        va.delete();
        vb.delete();
        vpat.delete();
    endtask

    initial begin
        Reset        = 1'b1;
        start        = 1'b0;
        length       = '0;
        in_valid     = 1'b0;
        in_a         = '0;
        in_b         = '0;
        result_ready = 1'b0;
        repeat (3) @(negedge Clock);
        check_val("rst busy", busy, 0);
        check_val("rst err", err, 0);
        check_val("rst in_ready", in_ready, 0);
        check_val("rst result_valid", result_valid, 0);
        check_val("rst result", result, 0);
        Reset = 1'b0;

        // 1*2 + 3*4 + 5*6 = 44
        va = '{1, 3, 5};
        vb = '{2, 4, 6};
        run_job("len3", 3, 0, 0);

        // 16 * 255*255 = 1040400
        check_val("w_acc", $bits(result), W_ACC);
        for (int i = 0; i < 16; i++) begin
            va.push_back(255);
            vb.push_back(255);
        end
        run_job("max", 16, 0, 0);

        // Gaps: valid pattern 1,0,0,1 -> 11*17 + 13*19 = 434
        va   = '{11, 13};
        vb   = '{17, 19};
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1};
        run_job("gap", 2, 2, 0);

        // Result held for 5 cycles with a start pulse in DONE
        va = '{200};
        vb = '{100};
        run_job("hold", 1, 0, 5);

        run_job("zero", 0, 0, 0);

        // length > MAX_LEN is rejected
        @(negedge Clock);
        start  = 1'b1;
        length = W_LEN'(17);
        @(negedge Clock);
        start = 1'b0;
        check_val("rej err", err, 1);
        check_val("rej busy", busy, 0);
        @(negedge Clock);
        check_val("rej err_drop", err, 0);
        check_val("rej busy2", busy, 0);

        // Abort a length-4 job after two pairs
        @(negedge Clock);
        start  = 1'b1;
        length = W_LEN'(4);
        @(negedge Clock);
        start    = 1'b0;
        in_valid = 1'b1;
        in_a     = 8'd50;
        in_b     = 8'd60;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset    = 1'b0;
        in_valid = 1'b0;
        check_val("abort busy", busy, 0);
        check_val("abort in_ready", in_ready, 0);
        check_val("abort result_valid", result_valid, 0);
        check_val("abort result", result, 0);
        va = '{7};
        vb = '{9};
        run_job("after_abort", 1, 0, 0);

        check_val("scoreboard empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dot_product_ctrl.md
Name: dot_product_ctrl

Overview:
- Sequencer for the registered unsigned multiplier (1-cycle latency, full-width product W_a+W_b).
- Accepts a job (`start` plus vector `length`), pulls `length` operand pairs over a valid/ready stream and feeds one pair per cycle to the multiplier.
- Accumulates products into an overflow-free accumulator and presents the dot product on a valid/ready result port.
- One instance per output element of the matrix-multiply engine.

Parameters:
- W_a, 32: bit-width of operand a.
- W_b, 32: bit-width of operand b.
- MAX_LEN, 16: maximum vector length per job; must be ≥1.
- W_len, $clog2(MAX_LEN+1): width of `length` and of the element counter (derived).
- W_acc, W_a+W_b+W_len: accumulator and result width (derived); guarantees no overflow at MAX_LEN.

Ports:
- Clock  in  1  sole clock; all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled in IDLE only.
- length  in  W_len  element count for the job, sampled with `start`.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle pulse: `start` rejected.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller accepts a pair this cycle.
- in_a  in  W_a  operand a, unsigned.
- in_b  in  W_b  operand b, unsigned.
- result  out  W_acc  dot product; held stable while `result_valid` is high.
- result_valid  out  1  result available.
- result_ready  in  1  consumer takes result.

Behaviour:
- Reset (synchronous, takes priority over every other condition):
  - State goes to IDLE.
  - busy=0, err=0, in_ready=0, result_valid=0, result=0.
  - Accumulator, element counter and product-valid flag cleared.
  - A reset asserted mid-job aborts the job; any in-flight product is discarded and no result is produced.
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - `start`=1 with 1≤length≤MAX_LEN: latch length, clear accumulator and counter, go to FEED.
  - `start`=1 with length=0: go to DONE with result=0.
  - `start`=1 with length>MAX_LEN: pulse `err` next cycle, stay in IDLE.
- FEED:
  - in_ready=1.
  - A pair is accepted when in_valid && in_ready. On acceptance, the pair drives the multiplier, the counter increments and a product-valid flag is registered alongside the product.
  - Stalls (in_valid=0) are allowed indefinitely; the counter holds.
  - The cycle after the pair that makes count==length is accepted, state goes to DRAIN.
  - in_ready is deasserted combinationally once count==length, so no extra pair is ever consumed.
- Accumulation:
  - In any cycle where the product-valid flag is set, accumulator <= accumulator + zero-extended product.
  - This is unsigned arithmetic at full W_acc width, with no wrap at MAX_LEN of all-ones operands.
- DRAIN:
  - Lasts exactly one cycle, during which the final product is added.
  - Then go to DONE; `result` is loaded from the accumulator.
- DONE:
  - result_valid=1; `result` is held stable.
  - When result_ready=1, go to IDLE and drop result_valid the next cycle.
  - `result` keeps its last value until the next load.
- Latency with in_valid held high: `start` sampled in cycle 0, pairs accepted in cycles 1..N, DRAIN in cycle N+1, result_valid high from cycle N+2.
  - For length=0: result_valid high in cycle 1.
- Simultaneous events:
  - `start` outside IDLE is ignored, with no err.
  - result_ready and `start` in the same DONE cycle: `start` is ignored; a new job requires IDLE.
- busy: 1 in FEED, DRAIN and DONE.

Decomposition:
- Shared package `mm_pkg`:
  - FSM state enum: IDLE, FEED, DRAIN, DONE.
  - Width helper functions: W_len and W_acc derivation.
- One sub-module: the existing registered multiplier `noOverflowMult`, instantiated once with parameters (W_a, W_b) and driven by Clock.
- Counter, accumulator and FSM stay in `dot_product_ctrl`.

Test Plan:
- W_a=W_b=8, length=3, pairs (1,2), (3,4), (5,6) with in_valid held high -> result=44 with result_valid first high in cycle 5 after `start`; in_ready low after the third accept.
- length=MAX_LEN=16, all pairs (255,255) -> result=1040400; no overflow; width check that W_acc=21.
- length=2, in_valid toggling 1,0,0,1 -> counter holds during the gaps; result equals the sum of the two products; exactly 2 pairs consumed.
- Hold result_ready=0 for 5 cycles in DONE -> result and result_valid stable; `start` pulsed during DONE is ignored, with err=0 and busy=1.
- length=0 -> result=0, result_valid in cycle 1. length=17 -> err pulse one cycle, busy stays 0.
- Assert Reset after 2 of 4 pairs -> next cycle busy=0, in_ready=0, result_valid=0; a fresh job (length=1, pair (7,9)) returns 63 with no residue from the aborted job.
